// File: rtl/fpu_txn_driver.sv
// Buffered request/response transaction driver for the mor1kx FPU port set.
// Optional rsp_latency output is enabled by defining FPU_TXN_DRV_LATENCY_EN.
`timescale 1ns/1ps
module fpu_txn_driver #(
  parameter int DATA_WIDTH     = 32,
  parameter int OP_WIDTH       = 8,
  parameter int RM_WIDTH       = 2,
  parameter int FLAG_WIDTH     = 12,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_opa,
  input  logic [DATA_WIDTH-1:0] req_opb,
  input  logic [OP_WIDTH-1:0]   req_op,
  input  logic [RM_WIDTH-1:0]   req_rm,
  input  logic                  req_is_cmp,
  output logic                  fpu_flush,
  output logic                  fpu_decode,
  output logic                  fpu_execute,
  output logic [OP_WIDTH-1:0]   fpu_op,
  output logic [RM_WIDTH-1:0]   fpu_rm,
  output logic [DATA_WIDTH-1:0] fpu_opa,
  output logic [DATA_WIDTH-1:0] fpu_opb,
  input  logic [DATA_WIDTH-1:0] fpu_out,
  input  logic                  fpu_valid_arith,
  input  logic                  fpu_cmp,
  input  logic                  fpu_valid_cmp,
  input  logic [FLAG_WIDTH-1:0] fpu_fpcsr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_cmp,
  output logic [FLAG_WIDTH-1:0] rsp_flags,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [15:0]           txn_count,
`ifdef FPU_TXN_DRV_LATENCY_EN
  output logic [15:0]           rsp_latency,
`endif
  output logic [2:0]            dbg_state
);

  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ENTRY_W = 2 * DATA_WIDTH + OP_WIDTH + RM_WIDTH + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_FLUSH  = 3'd5;
  localparam logic [2:0] S_DRAIN  = 3'd6;

  // Request FIFO
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               full, empty, push, pop;
  logic [DATA_WIDTH-1:0] h_opa, h_opb;
  logic [OP_WIDTH-1:0]   h_op;
  logic [RM_WIDTH-1:0]   h_rm;
  logic                  h_is_cmp;

  // FSM and datapath registers
  logic [2:0]            state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [RM_WIDTH-1:0]   rm_q, rm_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic                  is_cmp_q, is_cmp_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  cmp_q, cmp_d;
  logic [FLAG_WIDTH-1:0] flags_q, flags_d;
  logic                  tmo_q, tmo_d;
  logic [15:0]           txn_q, txn_d;
  logic                  sel_valid;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = req_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign {h_is_cmp, h_rm, h_op, h_opb, h_opa} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_is_cmp, req_rm, req_op, req_opb, req_opa};
  end

  // Pointers wrap for free because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FPU_TXN_DRV_LATENCY_EN
  logic [15:0] lat_q, lat_d, latency_q, latency_d;
  logic [15:0] lat_inc;
  assign lat_inc = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
`endif

  assign sel_valid = is_cmp_q ? fpu_valid_cmp : fpu_valid_arith;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rm_d     = rm_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    is_cmp_d = is_cmp_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    cmp_d    = cmp_q;
    flags_d  = flags_q;
    tmo_d    = tmo_q;
    txn_d    = txn_q;
`ifdef FPU_TXN_DRV_LATENCY_EN
    lat_d     = lat_q;
    latency_d = latency_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          op_d     = h_op;
          rm_d     = h_rm;
          opa_d    = h_opa;
          opb_d    = h_opb;
          is_cmp_d = h_is_cmp;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        cnt_d   = '0;
        state_d = S_WAIT;
`ifdef FPU_TXN_DRV_LATENCY_EN
        lat_d = 16'd1;
`endif
      end
      S_WAIT: begin
        // A valid on the last permitted cycle still beats the timeout.
        if (sel_valid) begin
          res_d   = is_cmp_q ? '0 : fpu_out;
          cmp_d   = is_cmp_q ? fpu_cmp : 1'b0;
          flags_d = fpu_fpcsr;
          tmo_d   = 1'b0;
          state_d = S_RESP;
`ifdef FPU_TXN_DRV_LATENCY_EN
          latency_d = lat_inc;
`endif
        end else if (cnt_q == TMO_LAST) begin
          res_d   = '0;
          cmp_d   = 1'b0;
          flags_d = '0;
          tmo_d   = 1'b1;
          state_d = S_RESP;
`ifdef FPU_TXN_DRV_LATENCY_EN
          latency_d = 16'(TIMEOUT_CYCLES);
`endif
        end else begin
          cnt_d = cnt_q + TW'(1);
`ifdef FPU_TXN_DRV_LATENCY_EN
          lat_d = lat_inc;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          txn_d   = txn_q + 16'd1;
          op_d    = '0;
          rm_d    = '0;
          opa_d   = '0;
          opb_d   = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        cnt_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Drain timeout is silent: the response has already been delivered.
        if ((fpu_out == '0) || (cnt_q == TMO_LAST)) state_d = S_IDLE;
        else cnt_d = cnt_q + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rm_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      is_cmp_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      cmp_q    <= 1'b0;
      flags_q  <= '0;
      tmo_q    <= 1'b0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rm_q     <= rm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      is_cmp_q <= is_cmp_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      cmp_q    <= cmp_d;
      flags_q  <= flags_d;
      tmo_q    <= tmo_d;
      txn_q    <= txn_d;
    end
  end

`ifdef FPU_TXN_DRV_LATENCY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_q     <= '0;
      latency_q <= '0;
    end else begin
      lat_q     <= lat_d;
      latency_q <= latency_d;
    end
  end
  assign rsp_latency = latency_q;
`endif

  assign req_ready   = !full;
  assign fpu_decode  = (state_q == S_DECODE);
  assign fpu_execute = (state_q == S_EXEC);
  assign fpu_flush   = (state_q == S_FLUSH);
  assign fpu_op      = op_q;
  assign fpu_rm      = rm_q;
  assign fpu_opa     = opa_q;
  assign fpu_opb     = opb_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_result  = res_q;
  assign rsp_cmp     = cmp_q;
  assign rsp_flags   = flags_q;
  assign rsp_timeout = tmo_q;
  assign busy        = (state_q != S_IDLE) || !empty;
  assign txn_count   = txn_q;
  assign dbg_state   = state_q;

endmodule
